// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract engine:
// state encoding, default operand width and a constant clog2 helper.
package serial_add_ctrl_pkg;

    // Controller state encoding; 2'd3 is illegal and recovers to IDLE.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit gate-level full adder cell used as the serial datapath.
// Ports:
//   a, b   : operand bits
//   cin    : carry in
//   sum    : sum bit
//   cout   : carry out
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic axb;

    assign axb  = a ^ b;
    assign sum  = axb ^ cin;
    assign cout = (a & b) | (axb & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. One fullAdder cell is sequenced over
// WIDTH cycles, LSB first, with the carry held in a flop between bits.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   start             : one-cycle request, accepted in IDLE or DONE
//   subtract          : 0 = A+B, 1 = A-B (sampled with start)
//   opA, opB          : operands (sampled with start)
//   busy              : high while bits are processed
//   done              : one-cycle pulse when the result is valid
//   sum               : result register
//   carryOut          : carry out of the MSB (subtract: 1 = no borrow)
//   overflow          : two's-complement overflow
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             overflow
);

    localparam int unsigned CW = clog2(WIDTH) + 1;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             load;
    logic             step;
    logic             last;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] acc;
    logic             carry;

    logic             fa_sum;
    logic             fa_cout;

    // Datapath: the single adder cell
    fullAdder u_fa (
        .a    (reg_a[0]),
        .b    (reg_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Back-to-back start is accepted exactly as in IDLE
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand shift registers, carry flop, counter and result registers.
    // busy/done are registered copies of the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carryOut <= 1'b0;
            overflow <= 1'b0;
            count    <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            acc      <= '0;
            carry    <= 1'b0;
        end else begin
            busy <= (state_next == ST_RUN);
            done <= (state_next == ST_DONE);

            if (load) begin
                // Subtract as A + ~B + 1: the +1 enters through the carry
                reg_a <= opA;
                reg_b <= subtract ? ~opB : opB;
                carry <= subtract;
                count <= '0;
            end else if (step) begin
                reg_a <= {1'b0, reg_a[WIDTH-1:1]};
                reg_b <= {1'b0, reg_b[WIDTH-1:1]};
                acc   <= {fa_sum, acc[WIDTH-1:1]};
                carry <= fa_cout;
                count <= count + CW'(1);
            end

            // MSB cycle: pre-update carry is the carry into the MSB
            if (last) begin
                sum      <= {fa_sum, acc[WIDTH-1:1]};
                carryOut <= fa_cout;
                overflow <= carry ^ fa_cout;
            end
        end
    end

endmodule
